// File: rtl/otbn_pq_pkg.sv
// Shared constants and types for the Keccak theta front end.
package otbn_pq_pkg;

  localparam int PQLEN       = 32;
  localparam int KeccakLaneW = 2 * PQLEN;
  localparam int KeccakDim   = 5;

  localparam logic [2:0] KeccakLastIdx = 3'(KeccakDim - 1);

  typedef enum logic [1:0] {
    ThetaAccum = 2'd0,
    ThetaCalc  = 2'd1,
    ThetaDrain = 2'd2
  } keccak_theta_state_e;

endpackage

// File: rtl/keccak_theta_d_calc.sv
// Theta D lanes from column parities: D[x] = C[x-1] ^ rotl1(C[x+1]).
module keccak_theta_d_calc
  import otbn_pq_pkg::*;
#(
  parameter int LaneW = KeccakLaneW
) (
  input  logic [KeccakDim-1:0][LaneW-1:0] c_i,
  output logic [KeccakDim-1:0][LaneW-1:0] d_o
);

  for (genvar x = 0; x < KeccakDim; x++) begin : g_col
    localparam int Xm = (x + KeccakDim - 1) % KeccakDim;
    localparam int Xp = (x + 1) % KeccakDim;
    assign d_o[x] = c_i[Xm] ^ {c_i[Xp][LaneW-2:0], c_i[Xp][LaneW-1]};
  end

endmodule

// File: rtl/keccak_theta_unit.sv
// Accumulates the 5 column parities of a streamed Keccak state, then drains
// the theta D lanes one per handshake to the downstream lane unit.
module keccak_theta_unit
  import otbn_pq_pkg::*;
#(
  parameter int LaneW = KeccakLaneW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             lane_valid_i,
  output logic             lane_ready_o,
  input  logic [LaneW-1:0] lane_i,
  output logic             d_valid_o,
  input  logic             d_ready_i,
  output logic [LaneW-1:0] d_o,
  output logic [2:0]       d_x_o,
  output logic             d_last_o,
  output logic             busy_o
);

  keccak_theta_state_e state_q, state_d;

  logic [2:0] x_cnt, y_cnt, out_x;
  logic [KeccakDim-1:0][LaneW-1:0] c_q, d_q, d_calc;
  logic lane_hs, d_hs;

  // Handshakes coinciding with clear are dropped.
  assign lane_hs = lane_valid_i & lane_ready_o & ~clear_i;
  assign d_hs    = d_valid_o & d_ready_i & ~clear_i;

  keccak_theta_d_calc #(.LaneW(LaneW)) u_d_calc (
    .c_i (c_q),
    .d_o (d_calc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ThetaAccum;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ThetaAccum: if (lane_hs && x_cnt == KeccakLastIdx && y_cnt == KeccakLastIdx)
                    state_d = ThetaCalc;
      ThetaCalc:  state_d = ThetaDrain;
      ThetaDrain: if (d_hs && out_x == KeccakLastIdx) state_d = ThetaAccum;
      default:    state_d = ThetaAccum;
    endcase
    if (clear_i) state_d = ThetaAccum;
  end

  always_comb begin
    lane_ready_o = (state_q == ThetaAccum);
    d_valid_o    = (state_q == ThetaDrain);
    d_o          = d_q[out_x];
    d_x_o        = out_x;
    d_last_o     = (out_x == KeccakLastIdx);
    busy_o       = (state_q != ThetaAccum) | (x_cnt != 3'd0) | (y_cnt != 3'd0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_cnt <= 3'd0;
      y_cnt <= 3'd0;
      out_x <= 3'd0;
      c_q   <= '0;
      d_q   <= '0;
    end else if (clear_i) begin
      x_cnt <= 3'd0;
      y_cnt <= 3'd0;
      out_x <= 3'd0;
    end else begin
      if (lane_hs) begin
        // Row 0 loads the parity, so no separate clear of C is needed.
        c_q[x_cnt] <= (y_cnt == 3'd0) ? lane_i : (c_q[x_cnt] ^ lane_i);
        if (x_cnt == KeccakLastIdx) begin
          x_cnt <= 3'd0;
          y_cnt <= (y_cnt == KeccakLastIdx) ? 3'd0 : y_cnt + 3'd1;
        end else begin
          x_cnt <= x_cnt + 3'd1;
        end
      end
      if (state_q == ThetaCalc) d_q <= d_calc;
      if (d_hs) out_x <= (out_x == KeccakLastIdx) ? 3'd0 : out_x + 3'd1;
    end
  end

endmodule
